// File: rtl/write_merge_buffer.sv
// Single-line store coalescing buffer: merges byte-masked stores into one line,
// fills holes from memory on eviction when needed, and forwards buffered bytes to loads.
module write_merge_buffer #(
    parameter int WORD_BYTES = 4,
    parameter int LINE_WORDS = 8,
    parameter int ADDR_W     = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 st_valid,
    input  logic [ADDR_W-1:0]                    st_addr,
    input  logic [8*WORD_BYTES-1:0]              st_wdata,
    input  logic [WORD_BYTES-1:0]                st_byte_enable,
    output logic                                 st_ready,
    input  logic                                 flush_req,
    output logic                                 idle,
    input  logic [ADDR_W-1:0]                    ld_addr,
    output logic [8*WORD_BYTES-1:0]              ld_rdata,
    output logic [WORD_BYTES-1:0]                ld_mask,
    output logic                                 mem_read,
    output logic                                 mem_write,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [8*WORD_BYTES*LINE_WORDS-1:0]   mem_wdata,
    input  logic [8*WORD_BYTES*LINE_WORDS-1:0]   mem_rdata,
    input  logic                                 mem_resp
);

    localparam int LINE_BYTES = WORD_BYTES * LINE_WORDS;
    localparam int LINE_BITS  = 8 * LINE_BYTES;
    localparam int WORD_BITS  = 8 * WORD_BYTES;
    localparam int OFF        = $clog2(LINE_BYTES);
    localparam int WOFF       = $clog2(WORD_BYTES);
    localparam int TAG_W      = ADDR_W - OFF;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_FILL  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic [LINE_BITS-1:0]   data_q, data_d;
    logic [LINE_BYTES-1:0]  mask_q, mask_d;

    logic [TAG_W-1:0]       st_tag, ld_tag;
    logic [OFF-WOFF-1:0]    st_widx, ld_widx;
    logic                   st_hit, ld_hit, evict, st_take;
    logic                   unused_low_bits;

    assign st_tag  = st_addr[ADDR_W-1:OFF];
    assign st_widx = st_addr[OFF-1:WOFF];
    assign ld_tag  = ld_addr[ADDR_W-1:OFF];
    assign ld_widx = ld_addr[OFF-1:WOFF];
    assign unused_low_bits = ^{st_addr[WOFF-1:0], ld_addr[WOFF-1:0]};

    assign st_hit = (st_tag == tag_q);
    assign ld_hit = (ld_tag == tag_q);

    // Flush wins over a same-tag store; a different-tag store forces eviction and stalls.
    assign evict    = (state_q == S_HOLD) && (flush_req || (st_valid && !st_hit));
    assign st_ready = (state_q == S_EMPTY) || ((state_q == S_HOLD) && !flush_req && st_hit);
    assign st_take  = st_valid && st_ready && (st_byte_enable != '0);

    assign idle      = (state_q == S_EMPTY);
    assign mem_read  = (state_q == S_FILL);
    assign mem_write = (state_q == S_WRITE);
    assign mem_addr  = {tag_q, {OFF{1'b0}}};
    assign mem_wdata = data_q;

    always_comb begin
        int bi;
        state_d = state_q;
        tag_d   = tag_q;
        data_d  = data_q;
        mask_d  = mask_q;
        bi      = 0;
        case (state_q)
            S_EMPTY: begin
                if (st_take) begin
                    tag_d   = st_tag;
                    data_d  = '0;
                    mask_d  = '0;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (evict) begin
                    state_d = (&mask_q) ? S_WRITE : S_FILL;
                end
            end
            S_FILL: begin
                if (mem_resp) begin
                    for (int b = 0; b < LINE_BYTES; b++) begin
                        if (!mask_q[b]) begin
                            data_d[b*8 +: 8] = mem_rdata[b*8 +: 8];
                        end
                    end
                    mask_d  = '1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (mem_resp) begin
                    mask_d  = '0;
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Merge applies on top of the allocation clear above, so a first store lands in a clean line.
        if (st_take) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (st_byte_enable[i]) begin
                    bi = int'(st_widx) * WORD_BYTES + i;
                    data_d[bi*8 +: 8] = st_wdata[i*8 +: 8];
                    mask_d[bi]        = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ld_rdata = '0;
        ld_mask  = '0;
        if ((state_q != S_EMPTY) && ld_hit) begin
            ld_rdata = data_q[int'(ld_widx)*WORD_BITS +: WORD_BITS];
            ld_mask  = mask_q[int'(ld_widx)*WORD_BYTES +: WORD_BYTES];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            tag_q   <= '0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

endmodule

// File: tb/tb_write_merge_buffer.sv
// Directed bench for write_merge_buffer: byte-array reference model checked every cycle,
// an expected-writeback queue, and hand-computed literals for each scenario.
module tb_write_merge_buffer;

    localparam int WB    = 4;
    localparam int LW    = 8;
    localparam int AW    = 32;
    localparam int LB    = WB * LW;
    localparam int LBITS = 8 * LB;
    localparam int OFF   = 5;
    localparam int CW    = AW + LBITS;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             st_valid = 1'b0;
    logic [AW-1:0]    st_addr = '0;
    logic [31:0]      st_wdata = '0;
    logic [WB-1:0]    st_byte_enable = '0;
    logic             st_ready;
    logic             flush_req = 1'b0;
    logic             idle;
    logic [AW-1:0]    ld_addr = '0;
    logic [31:0]      ld_rdata;
    logic [WB-1:0]    ld_mask;
    logic             mem_read;
    logic             mem_write;
    logic [AW-1:0]    mem_addr;
    logic [LBITS-1:0] mem_wdata;
    logic [LBITS-1:0] mem_rdata = {LB{8'hEE}};
    logic             mem_resp = 1'b0;

    write_merge_buffer #(.WORD_BYTES(WB), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_wdata(st_wdata),
        .st_byte_enable(st_byte_enable), .st_ready(st_ready),
        .flush_req(flush_req), .idle(idle),
        .ld_addr(ld_addr), .ld_rdata(ld_rdata), .ld_mask(ld_mask),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int wr_cyc = 0;
    int accept_cyc = 0;
    logic [AW-1:0] last_rd_addr = '0;
    bit chk_en = 0;
    bit resp_auto = 1;
    int lat = 0;

    logic [CW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 empty, 1 buffering, 2 waiting for line read, 3 waiting for line write
    int              m_phase = 0;
    logic [AW-OFF-1:0] m_tag = '0;
    logic [7:0]      m_byte[LB];
    bit              m_vld[LB];

    function automatic bit m_full();
        for (int b = 0; b < LB; b++) if (!m_vld[b]) return 0;
        return 1;
    endfunction

    task automatic m_merge();
        int w;
        w = int'(st_addr[OFF-1:2]);
        for (int i = 0; i < WB; i++) begin
            if (st_byte_enable[i]) begin
                m_byte[w*WB+i] = st_wdata[i*8 +: 8];
                m_vld[w*WB+i]  = 1;
            end
        end
    endtask

    always @(posedge clk) begin : model
        if (rst) begin
            m_phase = 0;
            for (int b = 0; b < LB; b++) m_vld[b] = 0;
        end else begin
            case (m_phase)
                0: if (st_valid && st_byte_enable != '0) begin
                    m_tag = st_addr[AW-1:OFF];
                    for (int b = 0; b < LB; b++) begin m_byte[b] = 8'h00; m_vld[b] = 0; end
                    m_merge();
                    m_phase = 1;
                end
                1: if (flush_req || (st_valid && st_addr[AW-1:OFF] != m_tag)) m_phase = m_full() ? 3 : 2;
                   else if (st_valid) m_merge();
                2: if (mem_resp) begin
                    for (int b = 0; b < LB; b++) begin
                        if (!m_vld[b]) m_byte[b] = mem_rdata[b*8 +: 8];
                        m_vld[b] = 1;
                    end
                    m_phase = 3;
                end
                3: if (mem_resp) begin
                    for (int b = 0; b < LB; b++) m_vld[b] = 0;
                    m_phase = 0;
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin : compare
        logic [LBITS-1:0] ml;
        logic [31:0] ew;
        logic [3:0]  em;
        bit          rdy;
        if (chk_en) begin
            for (int b = 0; b < LB; b++) ml[b*8 +: 8] = m_byte[b];
            rdy = (m_phase == 0) || (m_phase == 1 && !flush_req && st_addr[AW-1:OFF] == m_tag);
            chk("idle", CW'(idle), CW'(m_phase == 0));
            chk("mem_read", CW'(mem_read), CW'(m_phase == 2));
            chk("mem_write", CW'(mem_write), CW'(m_phase == 3));
            chk("st_ready", CW'(st_ready), CW'(rdy));
            if (m_phase >= 2) chk("mem_addr", CW'(mem_addr), CW'({m_tag, 5'b0}));
            if (m_phase == 3) chk("mem_wdata", CW'(mem_wdata), CW'(ml));
            ew = '0;
            em = '0;
            if (m_phase != 0 && ld_addr[AW-1:OFF] == m_tag) begin
                for (int i = 0; i < WB; i++) begin
                    ew[i*8 +: 8] = m_byte[int'(ld_addr[OFF-1:2])*WB + i];
                    em[i]        = m_vld[int'(ld_addr[OFF-1:2])*WB + i];
                end
            end
            chk("ld_rdata", CW'(ld_rdata), CW'(ew));
            chk("ld_mask", CW'(ld_mask), CW'(em));
        end
    end

    // ---------------- memory responder and writeback scoreboard ----------------
    always @(posedge clk) begin : responder
        #1;
        if (!resp_auto) begin
            lat = 0;
        end else if (rst) begin
            mem_resp = 1'b0;
            lat = 0;
        end else if ((mem_read || mem_write) && !mem_resp) begin
            if (lat == 2) begin mem_resp = 1'b1; lat = 0; end
            else lat++;
        end else begin
            mem_resp = 1'b0;
        end
    end

    always @(posedge clk) begin : monitor
        logic [CW-1:0] e;
        cyc++;
        if (!rst && mem_read) rd_cyc++;
        if (!rst && mem_read && mem_resp) begin
            rd_cnt++;
            last_rd_addr = mem_addr;
        end
        if (!rst && mem_write && mem_resp) begin
            wr_cnt++;
            wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL writeback_unexpected: got addr %0h, no writeback expected", mem_addr);
            end else begin
                e = exp_q.pop_front();
                chk("writeback", {mem_addr, mem_wdata}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        st_valid = 1'b1;
        st_addr = a;
        st_wdata = d;
        st_byte_enable = be;
        while (!acc && n < 200) begin
            #1;
            acc = st_ready;
            tick();
            n++;
        end
        accept_cyc = cyc;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL store_timeout: got no st_ready for addr %0h, required accept within 200 cycles", a);
        end
        st_valid = 1'b0;
        st_byte_enable = '0;
    endtask

    task automatic do_flush();
        int n;
        n = 0;
        flush_req = 1'b1;
        do begin
            tick();
            n++;
        end while (!idle && n < 200);
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL flush_timeout: got idle=0, required idle=1 within 200 cycles");
        end
        flush_req = 1'b0;
    endtask

    function automatic logic [LBITS-1:0] ee_line();
        return {LB{8'hEE}};
    endfunction

    // ---------------- directed stimulus ----------------
    initial begin : stim
        logic [LBITS-1:0] line;
        int r0, w0, n;

        tick();
        chk_en = 1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_idle", CW'(idle), CW'(1));
        chk("rst_st_ready", CW'(st_ready), CW'(1));
        chk("rst_mem_read", CW'(mem_read), CW'(0));
        chk("rst_mem_write", CW'(mem_write), CW'(0));
        chk("rst_ld_mask", CW'(ld_mask), CW'(0));

        // 1: full-line coalesce, no fill read
        r0 = rd_cyc;
        for (int k = 0; k < LW; k++) line[k*32 +: 32] = 32'hA0 + k;
        exp_q.push_back({32'h100, line});
        for (int k = 0; k < LW; k++) do_store(32'h100 + 4*k, 32'hA0 + k, 4'hF);
        do_flush();
        chk("t1_no_read", CW'(rd_cyc - r0), CW'(0));
        chk("t1_idle", CW'(idle), CW'(1));

        // 2: partial line read-modify-write
        r0 = rd_cnt;
        line = ee_line();
        line[31:0] = 32'hEE22EE44;
        exp_q.push_back({32'h200, line});
        do_store(32'h200, 32'h11223344, 4'b0101);
        do_flush();
        chk("t2_read_count", CW'(rd_cnt - r0), CW'(1));
        chk("t2_read_addr", CW'(last_rd_addr), CW'(32'h200));

        // 3: conflicting store stalls through the eviction of 0x300
        line = ee_line();
        line[31:0] = 32'h33333333;
        exp_q.push_back({32'h300, line});
        do_store(32'h300, 32'h33333333, 4'hF);
        do_store(32'h400, 32'h44444444, 4'hF);
        chk("t3_accept_after_write", CW'(accept_cyc - wr_cyc), CW'(1));
        ld_addr = 32'h400;
        #1;
        chk("t3_fwd_data", CW'(ld_rdata), CW'(32'h44444444));
        chk("t3_fwd_mask", CW'(ld_mask), CW'(4'hF));
        line = ee_line();
        line[31:0] = 32'h44444444;
        exp_q.push_back({32'h400, line});
        do_flush();

        // 4: overwrite and forwarding
        do_store(32'h500, 32'hDEADBEEF, 4'hF);
        do_store(32'h500, 32'h00005500, 4'b0010);
        ld_addr = 32'h500;
        #1;
        chk("t4_fwd_data", CW'(ld_rdata), CW'(32'hDEAD55EF));
        chk("t4_fwd_mask", CW'(ld_mask), CW'(4'hF));
        ld_addr = 32'h504;
        #1;
        chk("t4_other_word_mask", CW'(ld_mask), CW'(0));
        ld_addr = 32'h600;
        #1;
        chk("t4_miss_mask", CW'(ld_mask), CW'(0));
        chk("t4_miss_data", CW'(ld_rdata), CW'(0));
        line = ee_line();
        line[31:0] = 32'hDEAD55EF;
        exp_q.push_back({32'h500, line});
        do_flush();

        // 5: reset while a fill read is outstanding
        resp_auto = 0;
        mem_resp = 1'b0;
        do_store(32'h700, 32'h77777777, 4'h3);
        flush_req = 1'b1;
        n = 0;
        while (!mem_read && n < 20) begin tick(); n++; end
        chk("t5_reached_fill", CW'(mem_read), CW'(1));
        ld_addr = 32'h700;
        rst = 1'b1;
        flush_req = 1'b0;
        tick();
        chk("t5_read_dropped", CW'(mem_read), CW'(0));
        chk("t5_idle", CW'(idle), CW'(1));
        chk("t5_ld_mask", CW'(ld_mask), CW'(0));
        rst = 1'b0;
        w0 = wr_cnt;
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        chk("t5_stray_no_write", CW'(mem_write), CW'(0));
        tick();
        chk("t5_still_idle", CW'(idle), CW'(1));
        chk("t5_write_count", CW'(wr_cnt - w0), CW'(0));
        resp_auto = 1;

        // 6: degenerate cases
        do_store(32'h800, 32'h12345678, 4'h0);
        tick();
        chk("t6_be0_idle", CW'(idle), CW'(1));
        r0 = rd_cyc;
        w0 = wr_cnt;
        do_flush();
        repeat (3) tick();
        chk("t6_flush_empty_reads", CW'(rd_cyc - r0), CW'(0));
        chk("t6_flush_empty_writes", CW'(wr_cnt - w0), CW'(0));

        line = ee_line();
        line[31:0] = 32'h00000099;
        exp_q.push_back({32'h900, line});
        do_store(32'h900, 32'h00000099, 4'hF);
        st_valid = 1'b1;
        st_addr = 32'h904;
        st_wdata = 32'h12345678;
        st_byte_enable = 4'hF;
        flush_req = 1'b1;
        #1;
        chk("t6_flush_blocks_store", CW'(st_ready), CW'(0));
        n = 0;
        do begin tick(); n++; end while (!idle && n < 200);
        chk("t6_drained", CW'(idle), CW'(1));
        flush_req = 1'b0;
        do_store(32'h904, 32'h12345678, 4'hF);
        line = ee_line();
        line[63:32] = 32'h12345678;
        exp_q.push_back({32'h900, line});
        do_flush();

        repeat (2) tick();
        chk("exp_q_drained", CW'(exp_q.size()), CW'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish, required completion before time limit");
        $fatal(1);
    end

endmodule
